// File: rtl/regfile_dump.sv
// Register-file read-out engine: walks x0..x(NUM_REGS-1) through a spare read port and
// streams each value over valid/ready. Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_SEND,
`ifdef REGFILE_DUMP_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    idx_d   = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_READ: begin
                out_data_d  = rf_rdata;
                out_index_d = idx_q;
                out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                out_last_d  = 1'b0;
                csum_d      = csum_q ^ rf_rdata;
`else
                out_last_d  = (idx_q == LAST_IDX);
`endif
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    // out_last_q marks the word that ends the dump (checksum word when enabled).
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            S_CHK: begin
                out_data_d  = csum_q;
                out_index_d = '0;
                out_last_d  = 1'b1;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rf_addr   = (state_q == S_READ) ? idx_q : '0;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: table of expected stream words plus
// hand-written stall, reset-abort, held-start and mid-dump write sequences.
module tb_regfile_dump;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    localparam int NWORDS      = 33;
    localparam int DUMP_CYCLES = 67;
`else
    localparam int NWORDS      = 32;
    localparam int DUMP_CYCLES = 65;
`endif
    localparam int M_PLAIN = 0;
    localparam int M_STALL = 1;
    localparam int M_X7    = 2;
    localparam int M_RST   = 3;
    localparam logic [31:0] X7_OLD = 32'h1000_0007;
    localparam logic [31:0] X7_NEW = 32'hCAFE_0007;

    logic              clk, rst, start, busy, done, out_valid, out_ready, out_last;
    logic [ADDR_W-1:0] rf_addr, out_index;
    logic [DATA_W-1:0] rf_rdata, out_data;
    logic [DATA_W-1:0] rf_mem [NUM_REGS];

    assign rf_rdata = (rf_addr == '0) ? '0 : rf_mem[rf_addr];

    regfile_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } vec_t;

    vec_t                      vecs [NWORDS];
    logic [ADDR_W+DATA_W:0]    got [$];
    int                        checks = 0;
    int                        errors = 0;
    int                        done_cnt = 0;

    // Stream monitor: a word transfers at the next edge when valid && ready and no reset.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) got.push_back({out_last, out_index, out_data});
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic load_rf();
        for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    task automatic fill_table(input logic [31:0] x7_val);
        logic [31:0] cs;
        logic [31:0] d;
        cs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            d = (i == 0) ? 32'h0 : (i == 7) ? x7_val : 32'h1000_0000 + 32'(i);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            vecs[i] = '{ADDR_W'(i), d, 1'b0};
`else
            vecs[i] = '{ADDR_W'(i), d, (i == NUM_REGS - 1)};
`endif
            cs ^= d;
        end
`ifdef REGFILE_DUMP_CHECKSUM_EN
        vecs[NUM_REGS] = '{'0, cs, 1'b1};
`endif
    endtask

    task automatic check_words(input string tag, input int n);
        check({tag, "_count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got[i]),
                  64'({vecs[i].last, vecs[i].idx, vecs[i].data}));
    endtask

    task automatic run_dump(input int mode, input bit hold,
                            output int busy_cycles, output int done_at);
        int  stall_n;
        bit  stalling;
        bit  fired;
        bit  finished;
        busy_cycles = 0;
        done_at     = 0;
        stall_n     = 0;
        stalling    = 0;
        fired       = 0;
        finished    = 0;
        got.delete();
        @(posedge clk); #1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int n = 1; n <= 500; n++) begin
            @(negedge clk);
            if (mode == M_STALL && stalling) begin
                check("stall_valid", 64'(out_valid), 64'(1));
                check("stall_index", 64'(out_index), 64'(5));
                check("stall_data", 64'(out_data), 64'h1000_0005);
            end
            if (done && done_at == 0) done_at = n;
            if (!busy) begin
                finished = 1;
                break;
            end
            busy_cycles++;
            @(posedge clk); #1;
            rst = 1'b0;
            case (mode)
                M_STALL: begin
                    if (out_valid && out_index == 5 && stall_n < 10) begin
                        out_ready = 1'b0;
                        stalling  = 1;
                        stall_n++;
                    end else begin
                        stalling  = 0;
                        out_ready = 1'($urandom_range(0, 1));
                    end
                end
                M_X7: if (out_valid && out_index == 4) rf_mem[7] = X7_NEW;
                M_RST: if (out_valid && out_index == 12 && !fired) begin
                    rst   = 1'b1;
                    fired = 1;
                end
                default: ;
            endcase
        end
        if (!finished) check("dump_timeout_busy", 64'(busy), 64'(0));
        if (mode == M_STALL) check("stall_cycles", 64'(stall_n), 64'(10));
        out_ready = 1'b1;
    endtask

    initial begin
        int bc, da, dc0;
        load_rf();
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_index", 64'(out_index), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_addr", 64'(rf_addr), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Plain dump, ready tied high
        fill_table(X7_OLD);
        dc0 = done_cnt;
        run_dump(M_PLAIN, 0, bc, da);
        check_words("plain", NWORDS);
        check("plain_busy_cycles", 64'(bc), 64'(DUMP_CYCLES));
        check("plain_done_cycle", 64'(da), 64'(DUMP_CYCLES));
        check("plain_done_count", 64'(done_cnt - dc0), 64'(1));

        // Random backpressure with a 10-cycle stall on index 5
        dc0 = done_cnt;
        run_dump(M_STALL, 0, bc, da);
        check_words("stall", NWORDS);
        check("stall_done_count", 64'(done_cnt - dc0), 64'(1));

        // Reset while in SEND on index 12
        dc0 = done_cnt;
        run_dump(M_RST, 0, bc, da);
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_last", 64'(out_last), 64'(0));
        check_words("abort", 12);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - dc0), 64'(0));
        run_dump(M_PLAIN, 0, bc, da);
        check_words("restart", NWORDS);

        // Start held high for the whole dump; x7 rewritten mid-dump
        fill_table(X7_NEW);
        dc0 = done_cnt;
        run_dump(M_X7, 1, bc, da);
        check_words("hold", NWORDS);
        check("hold_busy_cycles", 64'(bc), 64'(DUMP_CYCLES));
        check("hold_done_count", 64'(done_cnt - dc0), 64'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_rebusy", 64'(busy), 64'(1));
        check("hold_reread_addr", 64'(rf_addr), 64'(0));
        check("hold_reread_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_second_valid", 64'(out_valid), 64'(1));
        check("hold_second_index", 64'(out_index), 64'(0));
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("final_idle", 64'(busy), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
